// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

   typedef enum logic {RUN, HALT} state_t;

   localparam int unsigned WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // A fetch address is usable only if word aligned and the whole word lies in memory.
   function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
      return (pc[1:0] == 2'b00) && (pc <= mem_bytes - WORD_BYTES);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; flush dominates push/pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] wr_pc,
   input  logic [31:0] wr_instr,
   output logic [31:0] rd_pc,
   output logic [31:0] rd_instr,
   output logic        full,
   output logic        empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   // Empty head reads as zero so Decode never sees stale storage.
   assign rd_pc    = empty ? '0 : mem[rd_ptr].pc;
   assign rd_instr = empty ? '0 : mem[rd_ptr].instr;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= '{pc: wr_pc, instr: wr_instr};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC owner: issues one fetch per cycle, queues results for Decode,
// handles Execute redirects and halts on misaligned / out-of-range PCs.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 256,
   parameter int unsigned DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] PCF,
   input  logic [31:0] instruction,
   input  logic        redirect_e,
   input  logic [31:0] redirect_pc_e,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic        valid_d,
   input  logic        ready_d,
   output logic        fault,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic        fault_q, fault_d;
   logic        push, pop, flush, full, empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         pcf_q       <= RESET_PC;
         fault_q     <= 1'b0;
         fetch_count <= '0;
      end else begin
         state_q <= state_d;
         pcf_q   <= pcf_d;
         fault_q <= fault_d;
         if (push) fetch_count <= fetch_count + 32'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      pcf_d   = pcf_q;
      fault_d = fault_q;
      flush   = 1'b0;
      pop     = 1'b0;
      push    = 1'b0;
      if (redirect_e) begin
         // Redirect wins over everything, including a halted fetch.
         flush = 1'b1;
         pcf_d = redirect_pc_e;
         if (pc_legal(redirect_pc_e, MEM_LIMIT)) begin
            state_d = RUN;
            fault_d = 1'b0;
         end else begin
            state_d = HALT;
            fault_d = 1'b1;
         end
      end else begin
         pop = ~empty & ready_d;
         if (state_q == RUN) begin
            if (!pc_legal(pcf_q, MEM_LIMIT)) begin
               state_d = HALT;
               fault_d = 1'b1;
            end else if (!full || pop) begin
               push  = 1'b1;
               pcf_d = pcf_q + 32'(WORD_BYTES);
            end
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .wr_pc    (pcf_q),
      .wr_instr (instruction),
      .rd_pc    (pc_d),
      .rd_instr (instr_d),
      .full     (full),
      .empty    (empty)
   );

   assign PCF     = pcf_q;
   assign fault   = fault_q;
   assign valid_d = ~empty;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_controller;

   localparam int unsigned DEPTH     = 4;
   localparam longint      MEM_BYTES = 256;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] PCF;
   logic [31:0] instruction;
   logic        redirect_e = 1'b0;
   logic [31:0] redirect_pc_e = '0;
   logic [31:0] instr_d, pc_d;
   logic        valid_d;
   logic        ready_d = 1'b0;
   logic        fault;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];
   assign instruction = mem[PCF[7:2]];

   fetch_controller #(.RESET_PC(32'h0), .MEM_BYTES(256), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .PCF           (PCF),
      .instruction   (instruction),
      .redirect_e    (redirect_e),
      .redirect_pc_e (redirect_pc_e),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .valid_d       (valid_d),
      .ready_d       (ready_d),
      .fault         (fault),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   ent_t        q[$];
   logic [31:0] m_pc = '0;
   logic [31:0] m_cnt = '0;
   bit          m_halt = 1'b0;
   bit          m_fault = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (longint'(a) <= MEM_BYTES - 4);
   endfunction

   task automatic model_update();
      if (reset) begin
         q.delete();
         m_pc = '0; m_cnt = '0; m_halt = 0; m_fault = 0;
      end else if (redirect_e) begin
         q.delete();
         m_pc    = redirect_pc_e;
         m_halt  = !legal(m_pc);
         m_fault = m_halt;
      end else begin
         if (q.size() > 0 && ready_d) void'(q.pop_front());
         if (!m_halt) begin
            if (!legal(m_pc)) begin
               m_halt = 1; m_fault = 1;
            end else if (q.size() < DEPTH) begin
               q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]]});
               m_pc  = m_pc + 4;
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic compare();
      chk("PCF", PCF, m_pc);
      chk("valid_d", 32'(valid_d), 32'(q.size() > 0));
      chk("pc_d", pc_d, (q.size() > 0) ? q[0].pc : 32'h0);
      chk("instr_d", instr_d, (q.size() > 0) ? q[0].instr : 32'h0);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect_e = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_e = 1'b1; redirect_pc_e = tgt;
      step();
      redirect_e = 1'b0;
   endtask

   initial begin
      bit seen;
      int r;
      logic [31:0] tgt;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;

      // Reset state and straight-line delivery
      @(negedge clk);
      do_reset();
      chk("rst_valid", 32'(valid_d), 0);
      chk("rst_pcf", PCF, 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_cnt", fetch_count, 0);
      chk("rst_pc_d", pc_d, 0);
      ready_d = 1'b1;
      step(); chk("seq_valid", 32'(valid_d), 1); chk("seq_pc0", pc_d, 0); chk("seq_i0", instr_d, mem[0]);
      step(); chk("seq_pc1", pc_d, 4); chk("seq_i1", instr_d, mem[1]);
      step(); chk("seq_pc2", pc_d, 8); chk("seq_cnt", fetch_count, 3);

      // Decode stall fills the queue, then drains in order
      do_reset();
      ready_d = 1'b0;
      repeat (10) step();
      chk("stall_pcf", PCF, 16);
      chk("stall_cnt", fetch_count, 4);
      ready_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", pc_d, 32'(4 * i));
         step();
      end

      // Redirect flushes queued entries with a two-cycle bubble
      do_reset();
      ready_d = 1'b0;
      repeat (3) step();
      ready_d = 1'b1;
      redirect(36);
      chk("redir_valid", 32'(valid_d), 0);
      chk("redir_pcf", PCF, 36);
      step(); chk("redir_valid2", 32'(valid_d), 1); chk("redir_pc", pc_d, 36);
      step(); chk("redir_next", pc_d, 40);

      // Sequential run-off past the last word halts; legal redirect recovers
      do_reset();
      redirect(240);
      seen = 0;
      for (int i = 0; i < 20 && !fault; i++) begin
         step();
         if (valid_d && pc_d == 252) seen = 1;
      end
      chk("runoff_252", 32'(seen), 1);
      chk("runoff_fault", 32'(fault), 1);
      repeat (3) step();
      chk("halt_cnt", fetch_count, 4);
      chk("halt_pcf", PCF, 256);
      redirect(4);
      chk("recov_fault", 32'(fault), 0);
      step(); chk("recov_pc", pc_d, 4);

      // Misaligned redirect, then reset while halted with a full queue
      do_reset();
      redirect(32'h0000_0006);
      chk("mis_fault", 32'(fault), 1);
      chk("mis_valid", 32'(valid_d), 0);
      step(); chk("mis_cnt", fetch_count, 0);
      do_reset();
      ready_d = 1'b0;
      redirect(240);
      repeat (6) step();
      chk("full_halt_fault", 32'(fault), 1);
      chk("full_halt_cnt", fetch_count, 4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("hrst_pcf", PCF, 0);
      chk("hrst_fault", 32'(fault), 0);
      chk("hrst_valid", 32'(valid_d), 0);
      chk("hrst_cnt", fetch_count, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         ready_d = ($urandom_range(0, 99) < 65);
         reset   = ($urandom_range(0, 199) == 0);
         redirect_e = ($urandom_range(0, 99) < (fault ? 25 : 5));
         r = $urandom_range(0, 99);
         if (r < 70)      tgt = 32'($urandom_range(0, 63)) * 4;
         else if (r < 85) tgt = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
         else if (r < 95) tgt = 32'($urandom_range(64, 1 << 20)) * 4;
         else             tgt = 32'hFFFF_FFFC;
         redirect_pc_e = tgt;
         step();
      end
      reset = 1'b0; redirect_e = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the pipeline's instruction memory: owns the fetch PC (PCF), issues one word-aligned fetch per cycle to the combinational, byte-addressed instruction memory and buffers the returned words with their PCs in a small queue feeding Decode over a valid/ready handshake. Execute-stage redirects (taken branch, jal/jalr) flush the queue and restart fetch at the target. Misaligned or out-of-range fetch addresses halt fetch and raise a sticky fault.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset
- MEM_BYTES, 256: instruction memory size in bytes; legal PCs are 0 .. MEM_BYTES-4
- DEPTH, 4: fetch queue entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- PCF  out  32  fetch address to instruction memory
- instruction  in  32  memory read data for PCF, valid same cycle
- redirect_e  in  1  PCSrcE from Execute: flush and refetch
- redirect_pc_e  in  32  PCTargetE
- instr_d  out  32  head-of-queue instruction
- pc_d  out  32  PC of instr_d
- valid_d  out  1  head entry valid
- ready_d  in  1  Decode accepts (low = StallD)
- fault  out  1  sticky: fetch halted on bad PC
- fetch_count  out  32  number of words enqueued since reset

## Operation
- States: RUN, HALT. Reset → RUN, PCF=RESET_PC, queue empty, valid_d=0, fault=0, fetch_count=0, instr_d/pc_d=0.
- pop = valid_d & ready_d. push = RUN & no redirect & (not full | pop).
- On push: enqueue {PCF, instruction}; PCF ← PCF+4; fetch_count ← +1 (wraps at 2^32).
- Full and no pop: PCF held, memory re-read next cycle (no side effects).
- Redirect (highest priority, any state): queue cleared (pop and push both suppressed), PCF ← redirect_pc_e. If redirect_pc_e[1:0]≠0 or redirect_pc_e > MEM_BYTES-4 → HALT, fault=1; else → RUN, fault cleared.
- RUN with PCF > MEM_BYTES-4 (sequential run-off): no push, → HALT, fault=1; queued entries still drain to Decode.
- HALT: no pushes, PCF held; left only by legal redirect or reset.
- Reset during any state or with full queue: same as power-on reset; in-flight entries discarded.
- PC arithmetic 32-bit unsigned, wraps; wrap yields out-of-range → HALT.

## Timing
- Reset release cycle 0: PCF=RESET_PC; entry enqueued at edge 0; valid_d=1 in cycle 1.
- Redirect asserted in cycle N: valid_d=0 in N+1 with PCF=target; target word at output in N+2 (two-cycle bubble).
- Steady state with ready_d=1: one instruction per cycle, pc_d increments by 4.
- Simultaneous pop and push on full queue: allowed, occupancy unchanged.
- Outputs instr_d/pc_d/valid_d registered from queue head; PCF registered. No combinational path ready_d→valid_d; push depends combinationally on ready_d when full.

## Structure
- Package fetch_pkg: state enum {RUN, HALT}, WORD_BYTES=4, queue entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_queue: synchronous FIFO of DEPTH entries with push/pop/flush, full/empty, occupancy counter with wrap-around pointers; flush dominates push/pop.
- Top: PC register, state FSM, range/alignment checks, fetch counter.

## Test plan
- Reset, ready_d=1, memory preloaded at 0,4,8: valid_d rises cycle 1, pc_d = 0,4,8 on consecutive cycles, fetch_count=3 after three pushes.
- ready_d=0 for 10 cycles: exactly DEPTH=4 entries enqueued, PCF stuck at 16, then ready_d=1 drains 0..12 in order with no loss/duplication.
- redirect_e with redirect_pc_e=36 while queue holds 3 entries: next cycle valid_d=0, cycle after pc_d=36, flushed entries never appear.
- Sequential fetch to PCF=252 with MEM_BYTES=256: 252 delivered, PCF=256 → HALT, fault=1, no further pushes; redirect to 4 clears fault, pc_d=4 two cycles later.
- Redirect to 32'h0000_0006: HALT, fault=1, valid_d=0; reset mid-HALT with full queue → PCF=0, fault=0, valid_d=0, fetch_count=0.
